// File: rtl/vas_pkg.sv
// Shared types for the vector apply/capture sequencer: FSM state encoding,
// default settle-counter width and the result-record layout seen by the logger.
package vas_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } vas_state_t;

    localparam int VAS_SETTLE_W = 4;

`ifndef VAS_REC_IN_W
`define VAS_REC_IN_W 1
`endif
`ifndef VAS_REC_OUT_W
`define VAS_REC_OUT_W 1
`endif

    // Record layout as packed by the response logger; widths follow the bench build.
    typedef struct packed {
        logic [`VAS_REC_IN_W:0]    idx;
        logic [`VAS_REC_IN_W-1:0]  stim;
        logic [`VAS_REC_OUT_W-1:0] resp;
    } vas_rec_t;

endpackage

// File: rtl/vas_settle_timer.sv
// Loadable down-counter that times the settle window; expire is high while the count is zero.
module vas_settle_timer #(
    parameter int W = 4
) (
    input  logic         CK,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge CK) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/vector_apply_sequencer.sv
// Applies stimulus vectors to a benchmark DUT, waits a settle time, captures the response and
// streams {idx, stim, resp} records. Optional golden comparison is enabled by GOLDEN_CMP_EN.
module vector_apply_sequencer
    import vas_pkg::*;
#(
    parameter int IN_W     = 1,
    parameter int OUT_W    = 1,
    parameter int SETTLE_W = VAS_SETTLE_W
) (
    input  logic                CK,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [IN_W:0]       cfg_count,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic [IN_W-1:0]     dut_in,
    input  logic [OUT_W-1:0]    dut_out,
    input  logic [OUT_W-1:0]    exp_out,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [IN_W:0]       rec_idx,
    output logic [IN_W-1:0]     rec_stim,
    output logic [OUT_W-1:0]    rec_resp,
    output logic                busy,
    output logic                done,
    output logic                mismatch,
    output logic [IN_W:0]       mis_cnt
);

    vas_state_t          state;
    logic [IN_W:0]       idx;
    logic [IN_W:0]       last;
    logic [SETTLE_W-1:0] settle_q;
    logic                settle_expire;
    logic                start_ok;

    // Counts above the pattern space are clamped; zero means the full space.
    function automatic logic [IN_W:0] last_index(input logic [IN_W:0] count);
        logic [IN_W:0] full;
        full = {1'b1, {IN_W{1'b0}}};
        if (count == '0 || count > full) begin
            return full - (IN_W+1)'(1);
        end
        return count - (IN_W+1)'(1);
    endfunction

    assign start_ok = start && !abort && (state == S_IDLE || state == S_DONE);

    vas_settle_timer #(.W(SETTLE_W)) u_settle (
        .CK       (CK),
        .reset    (reset),
        .load     (state == S_APPLY),
        .load_val (settle_q - SETTLE_W'(1)),
        .en       (state == S_SETTLE),
        .expire   (settle_expire)
    );

    always_ff @(posedge CK) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            last     <= '0;
            settle_q <= '0;
            dut_in   <= '0;
            rec_idx  <= '0;
            rec_stim <= '0;
            rec_resp <= '0;
        end else if (abort) begin
            state  <= S_IDLE;
            dut_in <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state    <= S_APPLY;
                        idx      <= '0;
                        last     <= last_index(cfg_count);
                        settle_q <= cfg_settle;
                    end
                end
                S_APPLY: begin
                    dut_in <= idx[IN_W-1:0];
                    state  <= (settle_q == '0) ? S_CAPTURE : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_expire) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    rec_resp <= dut_out;
                    rec_stim <= dut_in;
                    rec_idx  <= idx;
                    state    <= S_EMIT;
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        if (idx == last) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + (IN_W+1)'(1);
                            state <= S_APPLY;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rec_valid = (state == S_EMIT);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

`ifdef GOLDEN_CMP_EN
    always_ff @(posedge CK) begin
        if (reset || start_ok) begin
            mismatch <= 1'b0;
            mis_cnt  <= '0;
        end else if (!abort && state == S_CAPTURE && dut_out != exp_out) begin
            mismatch <= 1'b1;
            if (mis_cnt != '1) begin
                mis_cnt <= mis_cnt + (IN_W+1)'(1);
            end
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^exp_out;
    assign mismatch   = 1'b0;
    assign mis_cnt    = '0;
`endif

endmodule
